serial_mag_compare_ctrl: RTL and testbench

//  Sequencer that resolves an N-bit magnitude compare using one 1-bit compare

---
 rtl/serial_mag_compare_ctrl.sv | 170 +++++++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_compare_ctrl
//  Purpose  : Bit-serial magnitude comparator. Captures two WIDTH-bit operands
//             on an accepted start, then examines one bit pair per clock from
//             the MSB downward. The scan stops at the first differing bit.
//             The result is reported as one-hot lesser/greater/equal flags
//             together with a single-cycle done pulse.
//  Ports    : clk            rising-edge clock
//             rst_n          synchronous active-low reset
//             start          compare request, honoured only while idle
//             a_in, b_in     operands, captured on the accepted start edge
//             busy           high while a compare is in progress
//             done           one-cycle pulse, flags valid from this cycle
//             lesser/greater/equal   A<B / A>B / A==B (one-hot once done)
//             bits_examined  bit positions compared in the last operation
//  Revision : 1.0  initial release
// ============================================================================
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lesser,
    output logic             greater,
    output logic             equal,
    output logic [CNT_W-1:0] bits_examined
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [IDX_W-1:0] c_idx_msb = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_lesser;
    logic             r_greater;
    logic             r_equal;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_sh_nxt;
    logic [WIDTH-1:0] w_b_sh_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic             w_lesser_nxt;
    logic             w_greater_nxt;
    logic             w_equal_nxt;

    // The operands shift left each cycle, so the bit under examination
    // (original index r_idx) always sits in the MSB position.
    logic w_a_bit;
    logic w_b_bit;
    assign w_a_bit = r_a_sh[WIDTH-1];
    assign w_b_bit = r_b_sh[WIDTH-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_lesser  <= 1'b0;
            r_greater <= 1'b0;
            r_equal   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a_sh    <= w_a_sh_nxt;
            r_b_sh    <= w_b_sh_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_lesser  <= w_lesser_nxt;
            r_greater <= w_greater_nxt;
            r_equal   <= w_equal_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_a_sh_nxt    = r_a_sh;
        w_b_sh_nxt    = r_b_sh;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_lesser_nxt  = r_lesser;
        w_greater_nxt = r_greater;
        w_equal_nxt   = r_equal;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_a_sh_nxt    = a_in;
                    w_b_sh_nxt    = b_in;
                    w_idx_nxt     = c_idx_msb;
                    w_cnt_nxt     = '0;
                    w_lesser_nxt  = 1'b0;
                    w_greater_nxt = 1'b0;
                    w_equal_nxt   = 1'b0;
                    w_state_nxt   = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                if (r_cnt < c_cnt_max) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end

                if (w_a_bit && !w_b_bit) begin
                    w_greater_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (!w_a_bit && w_b_bit) begin
                    w_lesser_nxt = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_nxt  = r_idx - 1'b1;
                    w_a_sh_nxt = {r_a_sh[WIDTH-2:0], 1'b0};
                    w_b_sh_nxt = {r_b_sh[WIDTH-2:0], 1'b0};
                end else begin
                    // LSB reached with every bit pair matching.
                    w_equal_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded directly from registers
    // ------------------------------------------------------------------
    assign busy          = (r_state == ST_COMPARE);
    assign done          = r_done;
    assign lesser        = r_lesser;
    assign greater       = r_greater;
    assign equal         = r_equal;
    assign bits_examined = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mag_compare_ctrl
//  Purpose  : Self-checking bench for serial_mag_compare_ctrl (WIDTH=8).
//             Directed scenarios plus randomized operands, checked against an
//             arithmetic reference of the compare result and its latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_mag_compare_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             lesser;
    logic             greater;
    logic             equal;
    logic [CNT_W-1:0] bits_examined;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected results of the most recent completed operation.
    int last_l = 0;
    int last_g = 0;
    int last_e = 0;
    int last_bits = 0;

    serial_mag_compare_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_in          (a_in),
        .b_in          (b_in),
        .busy          (busy),
        .done          (done),
        .lesser        (lesser),
        .greater       (greater),
        .equal         (equal),
        .bits_examined (bits_examined)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Clocks from start acceptance to done: number of bits scanned from the
    // MSB down to and including the highest differing bit (all bits if equal).
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i]) return WIDTH - i;
        end
        return WIDTH;
    endfunction

    // Starts an operation at the current negedge and returns at the negedge
    // of its done cycle with start already lowered, so the caller may chain.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit noise);
        int n;
        int lat;
        bit seen;
        lat  = ref_lat(a, b);
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        chk("accept_flags", {lesser, greater, equal}, 0);
        chk("accept_bits", bits_examined, 0);
        n = 0;
        seen = 1'b0;
        while (n < 2 * WIDTH) begin
            if (noise) begin
                start = 1'($urandom % 2);
                a_in  = WIDTH'($urandom);
                b_in  = WIDTH'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("mid_busy", busy, 1);
            chk("mid_flags", {lesser, greater, equal}, 0);
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", n, lat);
        chk("done_busy", busy, 0);
        chk("lesser", lesser, (a < b) ? 1 : 0);
        chk("greater", greater, (a > b) ? 1 : 0);
        chk("equal", equal, (a == b) ? 1 : 0);
        chk("bits_examined", bits_examined, lat);
        last_l    = (a < b) ? 1 : 0;
        last_g    = (a > b) ? 1 : 0;
        last_e    = (a == b) ? 1 : 0;
        last_bits = lat;
    endtask

    // One idle cycle after done: pulse gone, results held.
    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_flags", {lesser, greater, equal}, {last_l[0], last_g[0], last_e[0]});
        chk("idle_bits", bits_examined, last_bits);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {lesser, greater, equal}, 0);
        chk("rst_bits", bits_examined, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal operands: full scan.
        run_op(8'hA5, 8'hA5, 1'b0);
        idle_check();
        // MSB differs: single cycle; then chained op accepted in done cycle.
        run_op(8'h80, 8'h7F, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0);
        idle_check();
        // LSB differs.
        run_op(8'h12, 8'h13, 1'b0);
        idle_check();
        // Differ at bit 3 with start pulses and operand churn while busy.
        run_op(8'h3C, 8'h34, 1'b1);
        idle_check();

        // Reset mid-operation discards the compare.
        a_in  = 8'hA5;
        b_in  = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flags", {lesser, greater, equal}, 0);
        chk("midrst_bits", bits_examined, 0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            chk("midrst_nodone", {done, busy}, 0);
        end
        last_l = 0; last_g = 0; last_e = 0; last_bits = 0;

        // Randomized operands, biased toward equal and single-bit differences.
        for (int k = 0; k < 400; k++) begin
            ra = WIDTH'($urandom);
            case ($urandom % 4)
                0: rb = ra;
                1: rb = ra ^ WIDTH'(1 << ($urandom % WIDTH));
                default: rb = WIDTH'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom % 2));
            if ($urandom % 2) idle_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
